// File: rtl/rob_dispatch_if.sv
// Dispatch-side bus between rename/dispatch and the ROB: per-slot instruction fields in,
// allocated row/bank and full back out.
interface rob_dispatch_if #(
  parameter int DW  = 2,
  parameter int DAW = 1,
  parameter int RAW = 3,
  parameter int PRW = 6
);
  logic [DW-1:0]           en;
  logic [DW-1:0][PRW-1:0]  phys_rd;
  logic [DW-1:0][4:0]      arch_rd;
  logic [DW-1:0]           is_branch_instr;
  logic [DW-1:0]           pred_taken;
  logic [DW-1:0][12:0]     br_offset;
  logic [DW-1:0][31:0]     pc;
  logic [DW-1:0][31:0]     instr;
  logic [DW-1:0][RAW-1:0]  rob_addr;
  logic [DW-1:0][DAW-1:0]  bank_addr;
  logic                    full;

  modport master (
    output en, phys_rd, arch_rd, is_branch_instr, pred_taken, br_offset, pc, instr,
    input  rob_addr, bank_addr, full
  );

  modport slave (
    input  en, phys_rd, arch_rd, is_branch_instr, pred_taken, br_offset, pc, instr,
    output rob_addr, bank_addr, full
  );
endinterface

// File: rtl/rob_dispatch_alloc.sv
// Reorder buffer: one row per dispatch group, one bank per slot; in-order retirement of the
// head row once every valid bank has written back. Commit outputs are combinational.
module rob_dispatch_alloc #(
  parameter int DISPATCH_WIDTH       = 2,
  parameter int DISPATCH_ADDR_WIDTH  = 1,
  parameter int ROB_ADDR_WIDTH       = 3,
  parameter int PHYS_REGS_ADDR_WIDTH = 6,
  parameter int WB_WIDTH             = 2
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  rob_dispatch_if.slave                                         disp,
  input  logic [WB_WIDTH-1:0]                                   wb_en_i,
  input  logic [WB_WIDTH-1:0][ROB_ADDR_WIDTH-1:0]               wb_rob_addr_i,
  input  logic [WB_WIDTH-1:0][DISPATCH_ADDR_WIDTH-1:0]          wb_bank_addr_i,
  input  logic [WB_WIDTH-1:0]                                   wb_taken_i,
  input  logic                                                  flush_i,
  output logic [DISPATCH_WIDTH-1:0]                             commit_en_o,
  output logic [DISPATCH_WIDTH-1:0][4:0]                        commit_arch_rd_o,
  output logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]   commit_phys_rd_o,
  output logic [DISPATCH_WIDTH-1:0][31:0]                       commit_pc_o,
  output logic [DISPATCH_WIDTH-1:0]                             commit_mispred_o,
  output logic [DISPATCH_WIDTH-1:0][12:0]                       commit_br_offset_o
);
  localparam int DW    = DISPATCH_WIDTH;
  localparam int DAW   = DISPATCH_ADDR_WIDTH;
  localparam int RAW   = ROB_ADDR_WIDTH;
  localparam int PRW   = PHYS_REGS_ADDR_WIDTH;
  localparam int WB    = WB_WIDTH;
  localparam int DEPTH = 1 << RAW;

  logic [RAW-1:0] head_q, head_d, tail_q, tail_d;
  logic [RAW:0]   count_q, count_d;

  logic [DEPTH-1:0][DW-1:0]          valid_q, valid_d, done_q, done_d, taken_q, taken_d;
  logic [DEPTH-1:0][DW-1:0]          isbr_q, isbr_d, pred_q, pred_d;
  logic [DEPTH-1:0][DW-1:0][PRW-1:0] phys_q, phys_d;
  logic [DEPTH-1:0][DW-1:0][4:0]     arch_q, arch_d;
  logic [DEPTH-1:0][DW-1:0][12:0]    off_q, off_d;
  logic [DEPTH-1:0][DW-1:0][31:0]    pc_q, pc_d;

  logic full, disp_fire, head_ready, commit_fire;

  // Raw instruction word is not needed by anything downstream of commit.
  logic unused_instr;
  assign unused_instr = ^disp.instr;

  always_comb begin
    full = (count_q == (RAW+1)'(DEPTH));
    disp.full = full;
    for (int i = 0; i < DW; i++) begin
      disp.rob_addr[i]  = tail_q;
      disp.bank_addr[i] = DAW'(i);
    end
  end

  assign disp_fire = (|disp.en) && !full;

  always_comb begin
    head_ready = (count_q != '0);
    for (int i = 0; i < DW; i++) begin
      if (valid_q[head_q][i] && !done_q[head_q][i]) head_ready = 1'b0;
    end
  end

  // A flushed head is not reported as retiring.
  assign commit_fire = head_ready && !flush_i;

  always_comb begin
    for (int i = 0; i < DW; i++) begin
      commit_en_o[i]        = commit_fire & valid_q[head_q][i];
      commit_arch_rd_o[i]   = arch_q[head_q][i];
      commit_phys_rd_o[i]   = phys_q[head_q][i];
      commit_pc_o[i]        = pc_q[head_q][i];
      commit_br_offset_o[i] = off_q[head_q][i];
      commit_mispred_o[i]   = commit_en_o[i] & isbr_q[head_q][i]
                              & (pred_q[head_q][i] ^ taken_q[head_q][i]);
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    taken_d = taken_q;
    isbr_d  = isbr_q;
    pred_d  = pred_q;
    phys_d  = phys_q;
    arch_d  = arch_q;
    off_d   = off_q;
    pc_d    = pc_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
    end else begin
      // Later ports overwrite earlier ones, so the highest k wins on a collision.
      for (int k = 0; k < WB; k++) begin
        if (wb_en_i[k] && valid_q[wb_rob_addr_i[k]][wb_bank_addr_i[k]]) begin
          done_d[wb_rob_addr_i[k]][wb_bank_addr_i[k]]  = 1'b1;
          taken_d[wb_rob_addr_i[k]][wb_bank_addr_i[k]] = wb_taken_i[k];
        end
      end
      if (commit_fire) begin
        valid_d[head_q] = '0;
        done_d[head_q]  = '0;
        head_d          = head_q + 1'b1;
      end
      if (disp_fire) begin
        valid_d[tail_q] = disp.en;
        done_d[tail_q]  = '0;
        isbr_d[tail_q]  = disp.is_branch_instr;
        pred_d[tail_q]  = disp.pred_taken;
        phys_d[tail_q]  = disp.phys_rd;
        arch_d[tail_q]  = disp.arch_rd;
        off_d[tail_q]   = disp.br_offset;
        pc_d[tail_q]    = disp.pc;
        tail_d          = tail_q + 1'b1;
      end
      unique case ({disp_fire, commit_fire})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      taken_q <= '0;
      isbr_q  <= '0;
      pred_q  <= '0;
      phys_q  <= '0;
      arch_q  <= '0;
      off_q   <= '0;
      pc_q    <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      taken_q <= taken_d;
      isbr_q  <= isbr_d;
      pred_q  <= pred_d;
      phys_q  <= phys_d;
      arch_q  <= arch_d;
      off_q   <= off_d;
      pc_q    <= pc_d;
    end
  end
endmodule

// File: tb/tb_rob_dispatch_alloc.sv
// Randomized + directed bench; ROB modelled as a queue of in-flight dispatch groups.
module tb_rob_dispatch_alloc;
  localparam int DW = 2, DAW = 1, RAW = 3, PRW = 6, WB = 2, DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rob_dispatch_if #(.DW(DW), .DAW(DAW), .RAW(RAW), .PRW(PRW)) dif ();

  logic [WB-1:0]           wb_en, wb_taken;
  logic [WB-1:0][RAW-1:0]  wb_row;
  logic [WB-1:0][DAW-1:0]  wb_bank;
  logic                    flush;
  logic [DW-1:0]           c_en, c_mis;
  logic [DW-1:0][4:0]      c_arch;
  logic [DW-1:0][PRW-1:0]  c_phys;
  logic [DW-1:0][31:0]     c_pc;
  logic [DW-1:0][12:0]     c_off;

  rob_dispatch_alloc #(
    .DISPATCH_WIDTH(DW), .DISPATCH_ADDR_WIDTH(DAW), .ROB_ADDR_WIDTH(RAW),
    .PHYS_REGS_ADDR_WIDTH(PRW), .WB_WIDTH(WB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .disp(dif),
    .wb_en_i(wb_en), .wb_rob_addr_i(wb_row), .wb_bank_addr_i(wb_bank), .wb_taken_i(wb_taken),
    .flush_i(flush),
    .commit_en_o(c_en), .commit_arch_rd_o(c_arch), .commit_phys_rd_o(c_phys),
    .commit_pc_o(c_pc), .commit_mispred_o(c_mis), .commit_br_offset_o(c_off)
  );

  typedef struct packed {
    logic [1:0]       v, d, t, br, pt;
    logic [1:0][5:0]  prd;
    logic [1:0][4:0]  ard;
    logic [1:0][12:0] off;
    logic [1:0][31:0] pc;
  } grp_t;

  grp_t q[$];
  int   m_head;
  int   n_vec, n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_head_ready();
    if (q.size() == 0) return 1'b0;
    return (q[0].v & ~q[0].d) == 2'b00;
  endfunction

  task automatic check_model();
    bit cm;
    logic [1:0] exp_en, exp_mis;
    cm = m_head_ready() && !flush;
    exp_en = cm ? q[0].v : 2'b00;
    exp_mis = 2'b00;
    chk("full", dif.full, q.size() == DEPTH);
    for (int i = 0; i < DW; i++) begin
      chk("rob_addr", dif.rob_addr[i], (m_head + q.size()) % DEPTH);
      chk("bank_addr", dif.bank_addr[i], i);
    end
    chk("commit_en", c_en, exp_en);
    for (int i = 0; i < DW; i++) begin
      if (exp_en[i]) begin
        exp_mis[i] = q[0].br[i] & (q[0].pt[i] != q[0].t[i]);
        chk("commit_arch_rd", c_arch[i], q[0].ard[i]);
        chk("commit_phys_rd", c_phys[i], q[0].prd[i]);
        chk("commit_pc", c_pc[i], q[0].pc[i]);
        chk("commit_br_offset", c_off[i], q[0].off[i]);
      end
    end
    chk("commit_mispred", c_mis, exp_mis);
  endtask

  task automatic model_update();
    int   pre_size, idx;
    bit   cm;
    grp_t g;
    if (!rst_n || flush) begin
      q.delete();
      m_head = 0;
      return;
    end
    pre_size = q.size();
    cm = m_head_ready();
    for (int k = 0; k < WB; k++) begin
      if (wb_en[k]) begin
        idx = (int'(wb_row[k]) - m_head + DEPTH) % DEPTH;
        if (idx < pre_size && q[idx].v[wb_bank[k]]) begin
          g = q[idx];
          g.d[wb_bank[k]] = 1'b1;
          g.t[wb_bank[k]] = wb_taken[k];
          q[idx] = g;
        end
      end
    end
    if (dif.en != 2'b00 && pre_size < DEPTH) begin
      g     = '0;
      g.v   = dif.en;
      g.br  = dif.is_branch_instr;
      g.pt  = dif.pred_taken;
      g.prd = dif.phys_rd;
      g.ard = dif.arch_rd;
      g.off = dif.br_offset;
      g.pc  = dif.pc;
      q.push_back(g);
    end
    if (cm) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
  endtask

  task automatic settle();
    #1;
    check_model();
  endtask

  task automatic advance();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    dif.en = '0;
    wb_en  = '0;
    flush  = 1'b0;
  endtask

  task automatic rand_fields();
    dif.phys_rd         = 12'($urandom);
    dif.arch_rd         = 10'($urandom);
    dif.is_branch_instr = 2'($urandom);
    dif.pred_taken      = 2'($urandom);
    dif.br_offset       = 26'($urandom);
    dif.pc              = {$urandom, $urandom};
    dif.instr           = {$urandom, $urandom};
  endtask

  task automatic set_wb(input int k, input int row, input int bank, input bit tk);
    wb_en[k]    = 1'b1;
    wb_row[k]   = RAW'(row);
    wb_bank[k]  = DAW'(bank);
    wb_taken[k] = tk;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    q.delete();
    m_head = 0;
    settle();
    chk("rst_full", dif.full, 0);
    chk("rst_rob_addr", dif.rob_addr[0], 0);
    chk("rst_commit_en", c_en, 0);
    chk("rst_commit_mispred", c_mis, 0);
    advance();
    rst_n = 1'b1;
  endtask

  task automatic fill8();
    for (int g = 0; g < DEPTH; g++) begin
      rand_fields();
      dif.en = 2'b11;
      settle();
      advance();
    end
    idle();
  endtask

  initial begin
    n_vec = 0; n_bad = 0; m_head = 0;
    rst_n = 1'b0;
    idle();
    rand_fields();
    wb_row = '0; wb_bank = '0; wb_taken = '0;
    @(negedge clk);

    // 1: first allocation lands in row 0, next in row 1
    do_reset();
    rand_fields();
    dif.en = 2'b11; dif.pc[0] = 32'h100; dif.pc[1] = 32'h104;
    settle();
    chk("s1_rob_addr", dif.rob_addr[0], 0);
    chk("s1_bank_addr0", dif.bank_addr[0], 0);
    chk("s1_bank_addr1", dif.bank_addr[1], 1);
    advance();
    idle();
    settle();
    chk("s1_next_rob_addr", dif.rob_addr[1], 1);
    advance();

    // 2: eight groups fill the ROB; a ninth is ignored
    do_reset();
    fill8();
    settle();
    chk("s2_full", dif.full, 1);
    dif.en = 2'b11;
    settle();
    advance();
    idle();
    settle();
    chk("s2_tail_wrapped", dif.rob_addr[0], 0);
    chk("s2_still_full", dif.full, 1);

    // 3: head waits for both banks; same-cycle writeback is not visible to commit
    set_wb(0, 0, 0, 1'b0);
    settle();
    advance();
    idle();
    settle();
    chk("s3_half_done", c_en, 2'b00);
    set_wb(1, 0, 1, 1'b0);
    settle();
    chk("s3_wb_same_cycle", c_en, 2'b00);
    advance();
    idle();
    settle();
    chk("s3_commit", c_en, 2'b11);
    advance();
    settle();
    chk("s3_after_commit", c_en, 2'b00);
    chk("s3_not_full", dif.full, 0);
    advance();

    // 4: partial group only waits on its valid bank
    do_reset();
    rand_fields();
    dif.en = 2'b01;
    settle();
    advance();
    idle();
    set_wb(0, 0, 0, 1'b0);
    settle();
    advance();
    idle();
    settle();
    chk("s4_commit_en", c_en, 2'b01);
    advance();

    // 5: mispredicted branch, then a correctly predicted one
    do_reset();
    rand_fields();
    dif.en = 2'b01; dif.is_branch_instr = 2'b01; dif.pred_taken = 2'b01;
    dif.br_offset[0] = 13'h123;
    settle();
    advance();
    dif.en = 2'b01; dif.is_branch_instr = 2'b01; dif.pred_taken = 2'b01;
    set_wb(0, 0, 0, 1'b0);
    settle();
    advance();
    idle();
    set_wb(0, 1, 0, 1'b1);
    settle();
    chk("s5_mispred", c_mis, 2'b01);
    chk("s5_br_offset", c_off[0], 13'h123);
    advance();
    idle();
    settle();
    chk("s5_correct_pred_en", c_en, 2'b01);
    chk("s5_correct_pred", c_mis, 2'b00);
    advance();

    // 6: full + commit + dispatch refuses dispatch; then flush
    do_reset();
    fill8();
    set_wb(0, 0, 0, 1'b0);
    set_wb(1, 0, 1, 1'b1);
    settle();
    advance();
    idle();
    rand_fields();
    dif.en = 2'b11;
    settle();
    chk("s6_full", dif.full, 1);
    chk("s6_commit", c_en, 2'b11);
    advance();
    idle();
    settle();
    chk("s6_count7", dif.full, 0);
    chk("s6_tail", dif.rob_addr[0], 0);
    dif.en = 2'b10;
    settle();
    advance();
    idle();
    settle();
    chk("s6_refill", dif.full, 1);
    flush = 1'b1;
    settle();
    advance();
    idle();
    settle();
    chk("s6_flush_full", dif.full, 0);
    chk("s6_flush_rob_addr", dif.rob_addr[0], 0);
    chk("s6_flush_commit", c_en, 2'b00);
    advance();

    // Randomized traffic with a mid-stream reset
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      rand_fields();
      if ($urandom_range(0, 99) < 55) dif.en = 2'($urandom_range(1, 3));
      for (int k = 0; k < WB; k++) begin
        if ($urandom_range(0, 99) < 60) begin
          if (q.size() != 0 && $urandom_range(0, 9) != 0)
            set_wb(k, (m_head + $urandom_range(0, q.size() - 1)) % DEPTH,
                   $urandom_range(0, 1), 1'($urandom));
          else
            set_wb(k, $urandom_range(0, DEPTH - 1), $urandom_range(0, 1), 1'($urandom));
        end
      end
      if ($urandom_range(0, 99) < 2) flush = 1'b1;
      if (cyc == 1500) begin
        rst_n = 1'b0;
        q.delete();
        m_head = 0;
      end
      settle();
      advance();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
